// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared size encodings, FSM states and request legality check
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RMW,
    ST_STORE,
    ST_RESP
  } lsu_state_t;

  // hi_nz: any address bit above the RAM's byte range is set
  function automatic logic lsu_req_err(input logic [1:0] size,
                                       input logic [1:0] lo,
                                       input logic       hi_nz);
    return hi_nz || (size == 2'd3) ||
           ((size == SZ_HALF) && lo[0]) ||
           ((size == SZ_WORD) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - load lane extract/extend and store lane merge
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr_lo,
  input  logic [1:0]      size,
  input  logic            is_unsigned,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data,
  output logic [XLEN-1:0] merged
);

  logic [4:0]      sh;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] mask;

  assign sh      = {addr_lo, 3'b000};
  assign shifted = rdata >> sh;

  always_comb begin
    load_data = rdata;
    mask      = '1;
    case (size)
      SZ_BYTE: begin
        load_data = {{(XLEN-8){~is_unsigned & shifted[7]}}, shifted[7:0]};
        mask      = {{(XLEN-8){1'b0}}, 8'hFF} << sh;
      end
      SZ_HALF: begin
        load_data = {{(XLEN-16){~is_unsigned & shifted[15]}}, shifted[15:0]};
        mask      = {{(XLEN-16){1'b0}}, 16'hFFFF} << sh;
      end
      default: begin
        load_data = rdata;
        mask      = '1;
      end
    endcase
  end

  // only the addressed lanes take store data; the rest keep the old word
  assign merged = (rdata & ~mask) | ((wdata << sh) & mask);

endmodule

// File: rtl/lsu_mem_master.sv
// rtl/lsu_mem_master.sv - load/store initiator for the single-port data RAM
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 1024
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [1:0]                req_size,
  input  logic                      req_unsigned,
  input  logic [XLEN-1:0]           req_addr,
  input  logic [XLEN-1:0]           req_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [XLEN-1:0]           rsp_rdata,
  output logic                      rsp_err,
  output logic                      mem_write_ena,
  output logic [$clog2(DEPTH)-1:0]  mem_addr,
  output logic [XLEN-1:0]           mem_data_o,
  input  logic [XLEN-1:0]           mem_data_i
);

  localparam int ADDR_W = $clog2(DEPTH);

  lsu_state_t      state;
  logic [1:0]      r_size;
  logic [1:0]      r_lo;
  logic            r_uns;
  logic [XLEN-1:0] r_wdata;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] merged;
  logic            req_err;

  assign req_ready = (state == ST_IDLE);
  assign req_err   = lsu_req_err(req_size, req_addr[1:0],
                                 |req_addr[XLEN-1:ADDR_W+2]);

  lsu_lane_align #(.XLEN(XLEN)) u_align (
    .rdata       (mem_data_i),
    .addr_lo     (r_lo),
    .size        (r_size),
    .is_unsigned (r_uns),
    .wdata       (r_wdata),
    .load_data   (load_data),
    .merged      (merged)
  );

  // mem_write_ena is its own flop so the RAM strobe cannot glitch on state decode
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      rsp_valid     <= 1'b0;
      rsp_err       <= 1'b0;
      rsp_rdata     <= '0;
      mem_write_ena <= 1'b0;
      mem_addr      <= '0;
      mem_data_o    <= '0;
      r_size        <= '0;
      r_lo          <= '0;
      r_uns         <= 1'b0;
      r_wdata       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            r_size  <= req_size;
            r_lo    <= req_addr[1:0];
            r_uns   <= req_unsigned;
            r_wdata <= req_wdata;
            if (req_err) begin
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
              rsp_valid <= 1'b1;
              state     <= ST_RESP;
            end else begin
              mem_addr <= req_addr[ADDR_W+1:2];
              if (!req_we) begin
                state <= ST_LOAD;
              end else if (req_size == SZ_WORD) begin
                mem_write_ena <= 1'b1;
                mem_data_o    <= req_wdata;
                state         <= ST_STORE;
              end else begin
                state <= ST_RMW;
              end
            end
          end
        end
        ST_LOAD: begin
          rsp_rdata <= load_data;
          rsp_err   <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RMW: begin
          mem_data_o    <= merged;
          mem_write_ena <= 1'b1;
          state         <= ST_STORE;
        end
        ST_STORE: begin
          mem_write_ena <= 1'b0;
          mem_data_o    <= '0;
          rsp_rdata     <= '0;
          rsp_err       <= 1'b0;
          rsp_valid     <= 1'b1;
          state         <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb/tb_lsu_mem_master.sv - directed self-checking bench for lsu_mem_master
module tb_lsu_mem_master;
  import lsu_pkg::*;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_write_ena;
  logic [9:0]  mem_addr;
  logic [31:0] mem_data_o;
  logic [31:0] mem_data_i;

  logic [31:0] ram [0:1023];
  int checks = 0;
  int fails  = 0;

  lsu_mem_master #(.XLEN(32), .DEPTH(1024)) dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_size      (req_size),
    .req_unsigned  (req_unsigned),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_rdata     (rsp_rdata),
    .rsp_err       (rsp_err),
    .mem_write_ena (mem_write_ena),
    .mem_addr      (mem_addr),
    .mem_data_o    (mem_data_o),
    .mem_data_i    (mem_data_i)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(negedge clock) if (mem_write_ena) ram[mem_addr] <= mem_data_o;
  assign mem_data_i = ram[mem_addr];

  // Issue one request from posedge+1 in IDLE; returns edges-to-rsp_valid counting the accept edge
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output int wc, output logic [31:0] rdata, output logic err);
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1; rsp_ready = 1'b1; lat = 0; wc = 0;
    do begin
      @(posedge clock); #1;
      lat++;
      req_valid = 1'b0;
      if (mem_write_ena) wc++;
    end while (!rsp_valid && lat < 10);
    rdata = rsp_rdata; err = rsp_err;
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    checks++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (mem_write_ena !== 1'b0) begin fails++; $display("FAIL reset_write_ena: got %b expected 0", mem_write_ena); end
    checks++; if (mem_data_o !== 32'h0) begin fails++; $display("FAIL reset_mem_data_o: got %h expected 0", mem_data_o); end
    checks++; if (mem_addr !== 10'h0) begin fails++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
  endtask

  task automatic test_word();
    int lat, wc; logic [31:0] rd; logic er;
    do_req(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, lat, wc, rd, er);
    checks++; if (lat !== 2) begin fails++; $display("FAIL word_store_latency: got %0d expected 2", lat); end
    checks++; if (wc !== 1) begin fails++; $display("FAIL word_store_wena_cycles: got %0d expected 1", wc); end
    checks++; if (er !== 1'b0 || rd !== 32'h0) begin fails++; $display("FAIL word_store_rsp: got err %b data %h expected 0/0", er, rd); end
    checks++; if (ram[4] !== 32'hDEADBEEF) begin fails++; $display("FAIL word_store_ram: got %h expected deadbeef", ram[4]); end
    do_req(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, lat, wc, rd, er);
    checks++; if (lat !== 2) begin fails++; $display("FAIL word_load_latency: got %0d expected 2", lat); end
    checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin fails++; $display("FAIL word_load_data: got %h err %b expected deadbeef err 0", rd, er); end
    checks++; if (wc !== 0) begin fails++; $display("FAIL word_load_wena: got %0d expected 0", wc); end
  endtask

  task automatic test_byte();
    int lat, wc; logic [31:0] rd; logic er;
    do_req(1'b1, SZ_WORD, 1'b0, 32'h10, 32'h11223344, lat, wc, rd, er);
    do_req(1'b1, SZ_BYTE, 1'b0, 32'h12, 32'hFFFFFFA5, lat, wc, rd, er);
    checks++; if (lat !== 3) begin fails++; $display("FAIL byte_store_latency: got %0d expected 3", lat); end
    checks++; if (wc !== 1) begin fails++; $display("FAIL byte_store_wena_cycles: got %0d expected 1", wc); end
    checks++; if (ram[4] !== 32'h11A53344) begin fails++; $display("FAIL byte_store_ram: got %h expected 11a53344", ram[4]); end
    do_req(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, lat, wc, rd, er);
    checks++; if (rd !== 32'h11A53344) begin fails++; $display("FAIL byte_word_load: got %h expected 11a53344", rd); end
    do_req(1'b0, SZ_BYTE, 1'b0, 32'h12, 32'h0, lat, wc, rd, er);
    checks++; if (rd !== 32'hFFFFFFA5) begin fails++; $display("FAIL byte_signed_load: got %h expected ffffffa5", rd); end
    do_req(1'b0, SZ_BYTE, 1'b1, 32'h12, 32'h0, lat, wc, rd, er);
    checks++; if (rd !== 32'h000000A5) begin fails++; $display("FAIL byte_unsigned_load: got %h expected 000000a5", rd); end
    do_req(1'b0, SZ_BYTE, 1'b0, 32'h13, 32'h0, lat, wc, rd, er);
    checks++; if (rd !== 32'h00000011) begin fails++; $display("FAIL byte_top_lane_load: got %h expected 00000011", rd); end
    do_req(1'b0, SZ_BYTE, 1'b0, 32'h10, 32'h0, lat, wc, rd, er);
    checks++; if (rd !== 32'h00000044) begin fails++; $display("FAIL byte_low_lane_load: got %h expected 00000044", rd); end
  endtask

  task automatic test_half();
    int lat, wc; logic [31:0] rd; logic er;
    do_req(1'b1, SZ_WORD, 1'b0, 32'h14, 32'h80017FFF, lat, wc, rd, er);
    do_req(1'b0, SZ_HALF, 1'b0, 32'h16, 32'h0, lat, wc, rd, er);
    checks++; if (rd !== 32'hFFFF8001) begin fails++; $display("FAIL half_signed_load: got %h expected ffff8001", rd); end
    do_req(1'b0, SZ_HALF, 1'b1, 32'h16, 32'h0, lat, wc, rd, er);
    checks++; if (rd !== 32'h00008001) begin fails++; $display("FAIL half_unsigned_load: got %h expected 00008001", rd); end
    do_req(1'b0, SZ_HALF, 1'b0, 32'h14, 32'h0, lat, wc, rd, er);
    checks++; if (rd !== 32'h00007FFF) begin fails++; $display("FAIL half_low_load: got %h expected 00007fff", rd); end
    do_req(1'b1, SZ_HALF, 1'b0, 32'h14, 32'h1234BEEF, lat, wc, rd, er);
    checks++; if (lat !== 3 || ram[5] !== 32'h8001BEEF) begin fails++; $display("FAIL half_store: got lat %0d ram %h expected 3 8001beef", lat, ram[5]); end
  endtask

  task automatic test_errors();
    int lat, wc; logic [31:0] rd; logic er;
    logic [1:0] s; logic [31:0] a; logic w;
    do_req(1'b1, SZ_WORD, 1'b0, 32'h0, 32'hCAFEF00D, lat, wc, rd, er);
    for (int i = 0; i < 5; i++) begin
      case (i)
        0:       begin w = 1'b1; s = SZ_HALF; a = 32'h3;    end
        1:       begin w = 1'b1; s = SZ_WORD; a = 32'h2;    end
        2:       begin w = 1'b1; s = 2'd3;    a = 32'h10;   end
        3:       begin w = 1'b1; s = SZ_WORD; a = 32'h1000; end
        default: begin w = 1'b0; s = SZ_HALF; a = 32'h3;    end
      endcase
      do_req(w, s, 1'b0, a, 32'hFFFFFFFF, lat, wc, rd, er);
      checks++; if (er !== 1'b1 || rd !== 32'h0) begin fails++; $display("FAIL err_case%0d_rsp: got err %b data %h expected 1/0", i, er, rd); end
      checks++; if (lat !== 1) begin fails++; $display("FAIL err_case%0d_latency: got %0d expected 1", i, lat); end
      checks++; if (wc !== 0) begin fails++; $display("FAIL err_case%0d_wena: got %0d expected 0", i, wc); end
    end
    checks++; if (ram[0] !== 32'hCAFEF00D) begin fails++; $display("FAIL err_ram0: got %h expected cafef00d", ram[0]); end
    checks++; if (ram[4] !== 32'h11A53344) begin fails++; $display("FAIL err_ram4: got %h expected 11a53344", ram[4]); end
  endtask

  task automatic test_boundary();
    int lat, wc; logic [31:0] rd; logic er;
    do_req(1'b1, SZ_WORD, 1'b0, 32'hFFC, 32'h0BADF00D, lat, wc, rd, er);
    checks++; if (er !== 1'b0 || ram[1023] !== 32'h0BADF00D) begin fails++; $display("FAIL top_word_store: got err %b ram %h expected 0 0badf00d", er, ram[1023]); end
    do_req(1'b0, SZ_BYTE, 1'b1, 32'hFFF, 32'h0, lat, wc, rd, er);
    checks++; if (er !== 1'b0 || rd !== 32'h0000000B) begin fails++; $display("FAIL top_byte_load: got err %b data %h expected 0 0000000b", er, rd); end
  endtask

  task automatic test_hold();
    int n;
    req_we = 1'b0; req_size = SZ_WORD; req_unsigned = 1'b0; req_addr = 32'h10; req_wdata = 32'h0;
    req_valid = 1'b1; rsp_ready = 1'b0; n = 0;
    do begin
      @(posedge clock); #1; n++;
      req_valid = 1'b0;
    end while (!rsp_valid && n < 10);
    checks++; if (rsp_valid !== 1'b1 || n !== 2) begin fails++; $display("FAIL hold_first_rsp: got valid %b after %0d expected 1 after 2", rsp_valid, n); end
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h11A53344 || req_ready !== 1'b0) begin
        fails++; $display("FAIL hold_cycle%0d: got valid %b data %h ready %b expected 1 11a53344 0", i, rsp_valid, rsp_rdata, req_ready);
      end
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clock); #1;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin fails++; $display("FAIL hold_release: got valid %b ready %b expected 0 1", rsp_valid, req_ready); end
    @(posedge clock); #1;
    checks++; if (ram[4] !== 32'h11A53344 || req_ready !== 1'b1) begin fails++; $display("FAIL hold_no_accept: got ram %h ready %b expected 11a53344 1", ram[4], req_ready); end
  endtask

  task automatic test_reset_mid(input logic [1:0] size, input logic [31:0] addr, input string tag);
    req_we = 1'b1; req_size = size; req_unsigned = 1'b0; req_addr = addr; req_wdata = 32'h0;
    req_valid = 1'b1; rsp_ready = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    #1 reset = 1'b1;
    #1;
    checks++; if (mem_write_ena !== 1'b0 || rsp_valid !== 1'b0) begin fails++; $display("FAIL %s_during_reset: got wena %b valid %b expected 0 0", tag, mem_write_ena, rsp_valid); end
    @(posedge clock); @(posedge clock); #1 reset = 1'b0;
    @(posedge clock); #1;
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin fails++; $display("FAIL %s_after_release: got ready %b valid %b expected 1 0", tag, req_ready, rsp_valid); end
    checks++; if (ram[4] !== 32'h11A53344) begin fails++; $display("FAIL %s_ram_unchanged: got %h expected 11a53344", tag, ram[4]); end
  endtask

  task automatic test_back_to_back();
    int lat, wc; logic [31:0] rd; logic er;
    do_req(1'b0, SZ_HALF, 1'b1, 32'h12, 32'h0, lat, wc, rd, er);
    checks++; if (req_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready: got %b expected 1", req_ready); end
    do_req(1'b0, SZ_HALF, 1'b1, 32'h10, 32'h0, lat, wc, rd, er);
    checks++; if (lat !== 2 || rd !== 32'h00003344) begin fails++; $display("FAIL b2b_second: got lat %0d data %h expected 2 00003344", lat, rd); end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b1;
    #12;
    test_reset();
    @(posedge clock); #1 reset = 1'b0;
    @(posedge clock); #1;
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_boundary();
    test_hold();
    test_reset_mid(SZ_BYTE, 32'h11, "reset_rmw");
    test_reset_mid(SZ_WORD, 32'h10, "reset_store");
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
